// File: rtl/dmem_responder_pkg.sv
// ============================================================
// dmem_responder_pkg : shared memory-interface types/constants
// Rev 1.0
// ============================================================
`default_nettype none

package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         WORD_W     = 32;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         WAIT_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================
// dmem_array : DEPTH x 32 RAM, synchronous write and read
// Rev 1.0
// ============================================================
`default_nettype none

module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================
// dmem_responder : valid/ready load/store responder with wait states
// Rev 1.0
// ============================================================
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int                    IDX_W     = $clog2(DEPTH);
    localparam int                    WORD_AW   = ADDR_W - 2;
    localparam logic [WORD_AW-1:0]    DEPTH_LIM = WORD_AW'(DEPTH);
    localparam bit                    DIRECT    = (WAIT_CYCLES == 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT  =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   cnt;
    logic                    cap_write;
    logic [ADDR_W-1:0]       cap_addr;
    logic [WORD_W-1:0]       cap_wdata;
    logic                    rdata_live;
    logic [WORD_W-1:0]       rdata_hold;
    logic [WORD_W-1:0]       ram_rdata;

    logic                    accept;
    logic                    commit;
    logic                    src_write;
    logic [ADDR_W-1:0]       src_addr;
    logic [WORD_W-1:0]       src_wdata;
    logic                    src_err;
    logic                    ram_we;
    logic [IDX_W-1:0]        ram_idx;

    // With zero wait states the request commits on its own accepting edge,
    // so the RAM is fed straight from the request port instead of the capture.
    always_comb begin
        accept = req_valid && req_ready;
        commit = ((state == WAIT) && (cnt == '0)) || (DIRECT && accept);
        if (state == WAIT) begin
            src_write = cap_write;
            src_addr  = cap_addr;
            src_wdata = cap_wdata;
        end else begin
            src_write = req_write;
            src_addr  = req_addr;
            src_wdata = req_wdata;
        end
        src_err = ((src_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                  (src_addr[ADDR_W-1:2] >= DEPTH_LIM);
        ram_we  = commit && src_write && !src_err;
        ram_idx = src_addr[IDX_W+1:2];
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (src_wdata),
        .rdata (ram_rdata)
    );

    // Load data is shown live from the RAM during RESP, then frozen.
    assign resp_rdata = rdata_live ? ram_rdata : rdata_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata_live <= 1'b0;
            rdata_hold <= '0;
        end else begin
            resp_valid <= commit;
            if (commit) begin
                resp_err   <= src_err;
                rdata_live <= !src_write && !src_err;
                rdata_hold <= '0;
            end else if (rdata_live) begin
                rdata_hold <= ram_rdata;
                rdata_live <= 1'b0;
            end

            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        state     <= DIRECT ? RESP : WAIT;
                        req_ready <= DIRECT;
                        busy      <= !DIRECT;
                    end else begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
